// File: rtl/glitch_cmd_decoder.sv
// rtl/glitch_cmd_decoder.sv - byte-stream command decoder driving glitcher registers
// Optional inter-byte timeout: define GLITCH_CMD_TIMEOUT_EN.
module glitch_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_TX_DV,
    output logic [7:0]  o_TX_Byte,
    input  logic        i_TX_Ready,
    output logic        o_glitch_delay_DV,
    output logic [31:0] o_glitch_delay,
    output logic        o_glitch_duration_DV,
    output logic [31:0] o_glitch_duration,
    output logic        o_glitch_ctrl_DV,
    output logic [7:0]  o_glitch_ctrl,
    input  logic [31:0] i_glitch_status,
    output logic        o_Overrun,
    output logic        o_Timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_TX      = 2'd2
    } state_t;

    localparam logic [7:0] OP_SET_DELAY    = 8'h01;
    localparam logic [7:0] OP_SET_DURATION = 8'h02;
    localparam logic [7:0] OP_SET_CTRL     = 8'h03;
    localparam logic [7:0] OP_GET_STATUS   = 8'h04;
    localparam logic [7:0] BYTE_ACK        = 8'hA5;
    localparam logic [7:0] BYTE_NAK        = 8'hEE;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] tx_sh_q, tx_sh_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] duration_q, duration_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        delay_dv_q, delay_dv_d;
    logic        duration_dv_q, duration_dv_d;
    logic        ctrl_dv_q, ctrl_dv_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic [31:0] asm_next;
    logic        tmo_hit;

    assign asm_next = {asm_q[23:0], i_RX_Byte};

`ifdef GLITCH_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Counter only runs while a frame is partially assembled.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_RX_DV || state_q != S_PAYLOAD) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (state_q == S_PAYLOAD) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        asm_d         = asm_q;
        tx_sh_d       = tx_sh_q;
        tx_cnt_d      = tx_cnt_q;
        delay_d       = delay_q;
        duration_d    = duration_q;
        ctrl_d        = ctrl_q;
        delay_dv_d    = 1'b0;
        duration_dv_d = 1'b0;
        ctrl_dv_d     = 1'b0;
        overrun_d     = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_RX_DV) begin
                    case (i_RX_Byte)
                        OP_SET_DELAY, OP_SET_DURATION: begin
                            op_d    = i_RX_Byte;
                            cnt_d   = 3'd4;
                            state_d = S_PAYLOAD;
                        end
                        OP_SET_CTRL: begin
                            op_d    = i_RX_Byte;
                            cnt_d   = 3'd1;
                            state_d = S_PAYLOAD;
                        end
                        OP_GET_STATUS: begin
                            tx_sh_d  = i_glitch_status;
                            tx_cnt_d = 3'd4;
                            state_d  = S_TX;
                        end
                        default: begin
                            tx_sh_d  = {BYTE_NAK, 24'h0};
                            tx_cnt_d = 3'd1;
                            state_d  = S_TX;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                // A byte landing on the timeout cycle is dropped with the frame.
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (i_RX_DV) begin
                    asm_d = asm_next;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        case (op_q)
                            OP_SET_DELAY: begin
                                delay_d    = asm_next;
                                delay_dv_d = 1'b1;
                            end
                            OP_SET_DURATION: begin
                                duration_d    = asm_next;
                                duration_dv_d = 1'b1;
                            end
                            default: begin
                                ctrl_d    = asm_next[7:0];
                                ctrl_dv_d = 1'b1;
                            end
                        endcase
                        tx_sh_d  = {BYTE_ACK, 24'h0};
                        tx_cnt_d = 3'd1;
                        state_d  = S_TX;
                    end
                end
            end
            S_TX: begin
                overrun_d = i_RX_DV;
                if (i_TX_Ready) begin
                    tx_sh_d  = {tx_sh_q[23:0], 8'h00};
                    tx_cnt_d = tx_cnt_q - 3'd1;
                    if (tx_cnt_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= S_IDLE;
            op_q          <= 8'h00;
            cnt_q         <= 3'd0;
            asm_q         <= 32'h0;
            tx_sh_q       <= 32'h0;
            tx_cnt_q      <= 3'd0;
            delay_q       <= 32'h0;
            duration_q    <= 32'h0;
            ctrl_q        <= 8'h00;
            delay_dv_q    <= 1'b0;
            duration_dv_q <= 1'b0;
            ctrl_dv_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            asm_q         <= asm_d;
            tx_sh_q       <= tx_sh_d;
            tx_cnt_q      <= tx_cnt_d;
            delay_q       <= delay_d;
            duration_q    <= duration_d;
            ctrl_q        <= ctrl_d;
            delay_dv_q    <= delay_dv_d;
            duration_dv_q <= duration_dv_d;
            ctrl_dv_q     <= ctrl_dv_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o_TX_DV              = (state_q == S_TX);
    assign o_TX_Byte            = tx_sh_q[31:24];
    assign o_glitch_delay_DV    = delay_dv_q;
    assign o_glitch_delay       = delay_q;
    assign o_glitch_duration_DV = duration_dv_q;
    assign o_glitch_duration    = duration_q;
    assign o_glitch_ctrl_DV     = ctrl_dv_q;
    assign o_glitch_ctrl        = ctrl_q;
    assign o_Overrun            = overrun_q;
    assign o_Timeout            = timeout_q;

endmodule
